// File: rtl/wb_uart_master_pkg.sv
// Shared definitions for the serial-link Wishbone debug master: command codes,
// status codes and FSM state encodings.
package wb_uart_master_pkg;

    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] CMD_WRN = 8'h11;
    localparam logic [7:0] CMD_RDN = 8'h12;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_ERR    = 8'h01;
    localparam logic [7:0] ST_TMO    = 8'h02;
    localparam logic [7:0] ST_BADCMD = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/wb_uart_master_txseq.sv
// Response byte sequencer: emits a status byte, optionally followed by four
// read-data bytes MSB first, honouring the transmitter busy handshake.
module wb_uart_master_txseq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  status,
    input  logic [31:0] rdata,
    input  logic        with_data,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    output logic        busy
);

    logic [39:0] shift_r;
    logic [2:0]  left_r;
    logic [7:0]  tx_data_r;
    logic        tx_wr_r;
    logic        send_s;

    // tx_busy is not yet valid in the cycle right after a pulse, so hold off then
    assign send_s = (left_r != 3'd0) && !tx_busy && !tx_wr_r;

    // byte queue, transmit strobe and held transmit data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= 40'h00_0000_0000;
            left_r    <= 3'd0;
            tx_data_r <= 8'h00;
            tx_wr_r   <= 1'b0;
        end else if (start) begin
            shift_r   <= {status, rdata};
            left_r    <= with_data ? 3'd5 : 3'd1;
            tx_wr_r   <= 1'b0;
        end else if (send_s) begin
            tx_data_r <= shift_r[39:32];
            shift_r   <= {shift_r[31:0], 8'h00};
            left_r    <= left_r - 3'd1;
            tx_wr_r   <= 1'b1;
        end else begin
            tx_wr_r   <= 1'b0;
        end
    end

    assign tx_data = tx_data_r;
    assign tx_wr   = tx_wr_r;
    assign busy    = (left_r != 3'd0);

endmodule

// File: rtl/wb_uart_master.sv
// Wishbone initiator controlled by host command bytes (parser, bus cycle engine,
// response sequencer). Optional address auto-increment: WB_UART_MASTER_AUTOINC_EN.
module wb_uart_master
    import wb_uart_master_pkg::*;
#(
    parameter int clk_freq    = 100000000,
    parameter int bus_timeout = 1024,
    parameter int byte_gap    = clk_freq / 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy
);

    localparam int GAP_W = $clog2(byte_gap + 1);
    localparam int TMO_W = $clog2(bus_timeout + 1);

    state_t            state_r, state_next_s;
    logic              cmd_we_r, cmd_we_next_s;
    logic [7:0]        status_r, status_next_s;
    logic [1:0]        byte_cnt_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [31:0]       addr_r;
    logic [31:0]       data_r;
    logic [31:0]       rdata_r;
    logic              cyc_r;
    logic              we_o_r;
    logic              busy_r;
    logic              tx_start_r;
    logic              seq_busy_s;
    logic              gap_hit_s;
    logic              tmo_hit_s;
    logic              shifting_s;
    logic              ack_ok_s;

    assign shifting_s = (state_r == S_ADDR) || (state_r == S_DATA);
    assign gap_hit_s  = (gap_cnt_r == GAP_W'(byte_gap));
    assign tmo_hit_s  = (tmo_cnt_r == TMO_W'(bus_timeout - 1));
    // err wins over a simultaneous ack
    assign ack_ok_s   = (state_r == S_BUS) && wb_ack_i && !wb_err_i;

    // next-state and command/status decode
    always_comb begin
        state_next_s  = state_r;
        cmd_we_next_s = cmd_we_r;
        status_next_s = status_r;
        case (state_r)
            S_IDLE: begin
                if (rx_avail) begin
                    case (rx_data)
                        CMD_WR: begin
                            state_next_s  = S_ADDR;
                            cmd_we_next_s = 1'b1;
                        end
                        CMD_RD: begin
                            state_next_s  = S_ADDR;
                            cmd_we_next_s = 1'b0;
                        end
`ifdef WB_UART_MASTER_AUTOINC_EN
                        CMD_WRN: begin
                            state_next_s  = S_DATA;
                            cmd_we_next_s = 1'b1;
                        end
                        CMD_RDN: begin
                            state_next_s  = S_BUS;
                            cmd_we_next_s = 1'b0;
                        end
`endif
                        default: begin
                            state_next_s  = S_RESP;
                            cmd_we_next_s = 1'b0;
                            status_next_s = ST_BADCMD;
                        end
                    endcase
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ADDR: begin
                if (rx_avail) begin
                    if (byte_cnt_r == 2'd3) begin
                        state_next_s = cmd_we_r ? S_DATA : S_BUS;
                    end else begin
                        state_next_s = S_ADDR;
                    end
                end else if (gap_hit_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_ADDR;
                end
            end
            S_DATA: begin
                if (rx_avail) begin
                    if (byte_cnt_r == 2'd3) begin
                        state_next_s = S_BUS;
                    end else begin
                        state_next_s = S_DATA;
                    end
                end else if (gap_hit_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DATA;
                end
            end
            S_BUS: begin
                if (wb_err_i) begin
                    state_next_s  = S_RESP;
                    status_next_s = ST_ERR;
                end else if (wb_ack_i) begin
                    state_next_s  = S_RESP;
                    status_next_s = ST_OK;
                end else if (tmo_hit_s) begin
                    state_next_s  = S_RESP;
                    status_next_s = ST_TMO;
                end else begin
                    state_next_s  = S_BUS;
                end
            end
            S_RESP: begin
                if (!tx_start_r && !seq_busy_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_RESP;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // state, latched command and bus/handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            cmd_we_r   <= 1'b0;
            status_r   <= 8'h00;
            cyc_r      <= 1'b0;
            we_o_r     <= 1'b0;
            busy_r     <= 1'b0;
            tx_start_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cmd_we_r   <= cmd_we_next_s;
            status_r   <= status_next_s;
            cyc_r      <= (state_next_s == S_BUS);
            we_o_r     <= (state_next_s == S_BUS) && cmd_we_next_s;
            busy_r     <= (state_next_s != S_IDLE);
            tx_start_r <= (state_next_s == S_RESP) && (state_r != S_RESP);
        end
    end

    // byte counter for the 4-byte address/data fields and inter-byte gap timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_r <= 2'd0;
            gap_cnt_r  <= '0;
        end else begin
            if (state_next_s != state_r) begin
                byte_cnt_r <= 2'd0;
            end else if (rx_avail && shifting_s) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
            end
            if (rx_avail || !shifting_s) begin
                gap_cnt_r <= '0;
            end else begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end
        end
    end

    // bus cycle timeout counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= '0;
        end else if (state_r == S_BUS) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // address/data shift-in (MSB first) and read data capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r  <= 32'h0000_0000;
            data_r  <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
        end else begin
            if ((state_r == S_ADDR) && rx_avail) begin
                addr_r <= {addr_r[23:0], rx_data};
`ifdef WB_UART_MASTER_AUTOINC_EN
            end else if (ack_ok_s) begin
                // persistent pointer; 32-bit add wraps FFFFFFFC -> 0
                addr_r <= addr_r + 32'd4;
`endif
            end
            if ((state_r == S_DATA) && rx_avail) begin
                data_r <= {data_r[23:0], rx_data};
            end
            if (ack_ok_s && !cmd_we_r) begin
                rdata_r <= wb_dat_i;
            end
        end
    end

    wb_uart_master_txseq u_txseq (
        .clk       (clk),
        .rst_n     (reset_n),
        .start     (tx_start_r),
        .status    (status_r),
        .rdata     (rdata_r),
        .with_data (!cmd_we_r && (status_r == ST_OK)),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .busy      (seq_busy_s)
    );

    assign wb_adr_o = {addr_r[31:2], 2'b00};
    assign wb_dat_o = data_r;
    assign wb_sel_o = 4'hF;
    assign wb_we_o  = we_o_r;
    assign wb_cyc_o = cyc_r;
    assign wb_stb_o = cyc_r;
    assign busy     = busy_r;

endmodule

// File: doc/wb_uart_master.md
Name: wb_uart_master

Overview:
- Wishbone initiator driven by a byte stream from the host serial link; gives the host direct read/write access to the bus for debug and bring-up.
- Connects to the interconnect as master m2, alongside the CPU instruction and data masters.
- Byte I/O comes from the shared UART byte core. This block contains only the command parser, the bus cycle engine and the response sequencer.

Parameters:
- clk_freq, 100000000, system clock in Hz; used only to derive the byte_gap default.
- bus_timeout, 1024, maximum cycles to wait for ack/err before aborting a bus cycle.
- byte_gap, clk_freq/100, maximum idle cycles between command bytes before the parser resets.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_avail  in  1  one-cycle strobe; rx_data is valid in that cycle
- tx_data  out  8  byte to transmit
- tx_wr  out  1  one-cycle transmit strobe
- tx_busy  in  1  transmitter busy
- wb_adr_o  out  32  bus address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte select; always 4'hF
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0, except wb_sel_o = 4'hF. FSM enters IDLE.
- Reset is asynchronous: asserting it mid-cycle drops wb_cyc_o and wb_stb_o immediately.
- Command protocol (bytes MSB first):
  - 0x01 write: cmd, A3..A0, D3..D0.
  - 0x02 read: cmd, A3..A0.
- FSM state IDLE: waits for rx_avail.
  - 0x01 or 0x02: latch the command and go to ADDR.
  - Any other byte: queue status 0xFF, go to RESP.
- FSM state ADDR: shifts in 4 bytes. After the 4th byte, a write goes to DATA and a read goes to BUS.
- FSM state DATA: shifts in 4 bytes, then goes to BUS.
- FSM state BUS:
  - Drive wb_cyc_o = wb_stb_o = 1, wb_we_o per command, wb_adr_o = {A[31:2], 2'b00}.
  - Terminate on the first cycle with ack or err. If both are high, err wins.
  - Otherwise terminate after bus_timeout cycles.
  - cyc and stb deassert the cycle after termination.
  - Read data is captured on the ack cycle.
  - Status: 0x00 on ack, 0x01 on err, 0x02 on timeout.
- FSM state RESP: sends the status byte. For a read with status 0x00, then sends D3..D0 of the captured data. Then returns to IDLE.
- Transmit handshake:
  - tx_wr pulses for one cycle only when tx_busy = 0.
  - The sequencer ignores tx_busy in the cycle after a pulse; tx_busy is valid from the second cycle.
  - tx_data is held from the tx_wr cycle until the next pulse.
- Inter-byte gap counter:
  - Runs in ADDR and DATA only, and restarts on every rx_avail.
  - When it reaches byte_gap: discard the partial command, return to IDLE, send no response.
- Bytes arriving in BUS or RESP are dropped.
- Address and data shift registers load MSB-first: reg <= {reg[23:0], rx_data}.
- Worst-case latency from the last command byte to stb is 1 cycle.

Optional Feature:
- Macro: WB_UART_MASTER_AUTOINC_EN.
- When defined:
  - An address register persists across commands and increments by 4 after every access that terminates with ack; it wraps from 32'hFFFFFFFC to 0.
  - New command 0x11 (write-next, followed by D3..D0) and 0x12 (read-next) use that register and skip ADDR.
  - Commands 0x01 and 0x02 load the register.
- When undefined: 0x11 and 0x12 are unknown commands and return 0xFF; address is not retained.

Decomposition:
- Shared package wb_uart_master_pkg holds:
  - command codes: CMD_WR=8'h01, CMD_RD=8'h02, CMD_WRN=8'h11, CMD_RDN=8'h12;
  - status codes: ST_OK=8'h00, ST_ERR=8'h01, ST_TMO=8'h02, ST_BADCMD=8'hFF;
  - FSM state encodings.
- One natural sub-module: wb_uart_master_txseq, a byte-sequencer for the status byte plus up to 4 data bytes, with the tx handshake.

Test Plan:
- Write: send 01 00 00 10 04 DE AD BE EF; slave acks after 3 cycles -> one bus cycle with adr=32'h00001004, dat=32'hDEADBEEF, we=1, sel=F; response 00.
- Read: send 02 00 00 10 04; slave returns 32'h12345678 with ack -> response 00 12 34 56 78; wb_we_o=0 throughout.
- Error and timeout: slave asserts err with ack in the same cycle -> response 01. No slave reply -> cyc drops after exactly 1024 cycles, response 02.
- Bad command and gap: byte 0x55 -> response FF. Send 01 00 then idle for byte_gap cycles -> no bus cycle, no response, busy=0.
- Reset mid-cycle: pull reset_n low while stb is high -> cyc/stb/tx_wr low the same cycle; after release, a read command completes normally.
- AUTOINC_EN: send 02 00 00 00 FC, then 12, then 12 -> three reads at addresses FC, 100, 104; each responds 00 followed by its data.
